lsu_mem_master: RTL and testbench

//  Load/store initiator on the data-memory port. Accepts one CPU load/store at a time, checks range and

---
 rtl/lsu_mem_master_if.sv | 48 ++++
 rtl/lsu_mem_master.sv | 204 ++++++++++++++++++++
 tb/tb_lsu_mem_master.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// +--------------------------------------------------------------------------+
// | lsu_mem_master_if : CPU request/response and data-memory port bundle      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

interface lsu_mem_master_if #(
  parameter int WA_W = 5
);
  logic            req_valid;
  logic            req_ready;
  logic            req_store;
  logic [2:0]      req_funct3;
  logic [31:0]     req_addr;
  logic [31:0]     req_wdata;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [31:0]     rsp_rdata;
  logic            rsp_err;

  logic            mem_en;
  logic            mem_we;
  logic [3:0]      mem_be;
  logic [WA_W-1:0] mem_addr;
  logic [31:0]     mem_wdata;
  logic [31:0]     mem_rdata;

  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata,
    output req_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata,
    input  req_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

`default_nettype wire

// File: rtl/lsu_mem_master.sv
// +--------------------------------------------------------------------------+
// | lsu_mem_master : load/store initiator, splits word-crossing accesses      |
// | Option macro MISALIGN_TRAP_EN: misaligned H/W return an error. Rev 1.0    |
// +--------------------------------------------------------------------------+
`default_nettype none

module lsu_mem_master #(
  parameter int MEM_BYTES = 128,
  parameter int WA_W      = 5
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  lsu_mem_master_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE0 = 3'd1,
    S_CAP0   = 3'd2,
    S_ISSUE1 = 3'd3,
    S_CAP1   = 3'd4,
    S_RESP   = 3'd5
  } state_t;

  localparam logic [32:0] c_mem_bytes = 33'(MEM_BYTES);

  function automatic logic [2:0] size_of(input logic [1:0] f);
    case (f)
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  state_t          r_state;
  state_t          w_next;

  logic            r_store;
  logic [2:0]      r_funct3;
  logic [1:0]      r_off;
  logic [WA_W-1:0] r_word;
  logic [31:0]     r_wdata;
  logic            r_err;
  logic [31:0]     r_w0;
  logic [31:0]     r_w1;

  // Request decode, evaluated on the live request fields at acceptance
  logic [2:0]  w_req_size;
  logic [32:0] w_req_end;
  logic        w_f3_ok;
  logic        w_align_err;
  logic        w_req_err;
  logic        w_accept;

  assign w_req_size = size_of(bus.req_funct3[1:0]);
  assign w_req_end  = {1'b0, bus.req_addr} + {30'd0, w_req_size} - 33'd1;
  assign w_f3_ok    = (bus.req_funct3 == 3'b000) || (bus.req_funct3 == 3'b001) ||
                      (bus.req_funct3 == 3'b010) || (bus.req_funct3 == 3'b100) ||
                      (bus.req_funct3 == 3'b101);

`ifdef MISALIGN_TRAP_EN
  assign w_align_err = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                       ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
`else
  assign w_align_err = 1'b0;
`endif

  assign w_req_err = !w_f3_ok || (bus.req_store && bus.req_funct3[2]) ||
                     (w_req_end >= c_mem_bytes) || w_align_err;
  assign w_accept  = bus.req_valid && bus.req_ready;

  // Datapath on the registered request
  logic [2:0]  w_size;
  logic [3:0]  w_lane_end;
  logic        w_cross;
  logic [3:0]  w_base_be;
  logic [7:0]  w_be_wide;
  logic [63:0] w_data_wide;
  logic [31:0] w_merged;
  logic [31:0] w_load_data;

  assign w_size     = size_of(r_funct3[1:0]);
  assign w_lane_end = {2'b00, r_off} + {1'b0, w_size};

`ifdef MISALIGN_TRAP_EN
  assign w_cross = 1'b0;
`else
  assign w_cross = (w_lane_end > 4'd4);
`endif

  assign w_base_be   = (w_size == 3'd1) ? 4'b0001 : (w_size == 3'd2) ? 4'b0011 : 4'b1111;
  // Upper halves of the widened shifts are exactly the second-word lanes/data
  assign w_be_wide   = {4'b0000, w_base_be} << r_off;
  assign w_data_wide = {32'd0, r_wdata} << {r_off, 3'b000};
  assign w_merged    = 32'({r_w1, r_w0} >> {r_off, 3'b000});

  always_comb begin
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_merged[7]}}, w_merged[7:0]};
      3'b001:  w_load_data = {{16{w_merged[15]}}, w_merged[15:0]};
      3'b100:  w_load_data = {24'd0, w_merged[7:0]};
      3'b101:  w_load_data = {16'd0, w_merged[15:0]};
      default: w_load_data = w_merged;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_store  <= 1'b0;
      r_funct3 <= 3'd0;
      r_off    <= 2'd0;
      r_word   <= '0;
      r_wdata  <= 32'd0;
      r_err    <= 1'b0;
      r_w0     <= 32'd0;
      r_w1     <= 32'd0;
    end else begin
      if (w_accept) begin
        r_store  <= bus.req_store;
        r_funct3 <= bus.req_funct3;
        r_off    <= bus.req_addr[1:0];
        r_word   <= bus.req_addr[WA_W+1:2];
        r_wdata  <= bus.req_wdata;
        r_err    <= w_req_err;
      end
      if (r_state == S_CAP0) begin
        r_w0 <= bus.mem_rdata;
      end
      if (r_state == S_CAP1) begin
        r_w1 <= bus.mem_rdata;
      end
    end
  end

  always_comb begin
    w_next        = r_state;
    bus.req_ready = 1'b0;
    bus.rsp_valid = 1'b0;
    bus.rsp_rdata = 32'd0;
    bus.rsp_err   = 1'b0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = 32'd0;
    case (r_state)
      S_IDLE: begin
        // Gated by rst_n so every output reads 0 while reset is held
        bus.req_ready = rst_n;
        if (w_accept) begin
          w_next = w_req_err ? S_RESP : S_ISSUE0;
        end
      end
      S_ISSUE0: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = r_store;
        bus.mem_be    = w_be_wide[3:0];
        bus.mem_addr  = r_word;
        bus.mem_wdata = r_store ? w_data_wide[31:0] : 32'd0;
        if (!r_store) begin
          w_next = S_CAP0;
        end else begin
          w_next = w_cross ? S_ISSUE1 : S_RESP;
        end
      end
      S_CAP0: begin
        w_next = w_cross ? S_ISSUE1 : S_RESP;
      end
      S_ISSUE1: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = r_store;
        bus.mem_be    = w_be_wide[7:4];
        bus.mem_addr  = r_word + {{(WA_W-1){1'b0}}, 1'b1};
        bus.mem_wdata = r_store ? w_data_wide[63:32] : 32'd0;
        w_next        = r_store ? S_RESP : S_CAP1;
      end
      S_CAP1: begin
        w_next = S_RESP;
      end
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        bus.rsp_err   = r_err;
        bus.rsp_rdata = (r_store || r_err) ? 32'd0 : w_load_data;
        if (bus.rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
// +--------------------------------------------------------------------------+
// | tb_lsu_mem_master : directed self-checking bench for lsu_mem_master       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_lsu_mem_master;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  lsu_mem_master_if #(.WA_W(5)) bus ();

  lsu_mem_master #(.MEM_BYTES(128), .WA_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Memory model: byte[a] reads a^8'h80 until written
  bit [7:0] mb [0:127];
  bit       wr [0:127];

  function automatic logic [7:0] rbyte(input int a);
    return wr[a] ? mb[a] : (8'(a) ^ 8'h80);
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) begin
        for (int l = 0; l < 4; l++) begin
          if (bus.mem_be[l]) begin
            mb[int'(bus.mem_addr)*4 + l] <= bus.mem_wdata[8*l +: 8];
            wr[int'(bus.mem_addr)*4 + l] <= 1'b1;
          end
        end
      end else begin
        bus.mem_rdata <= {rbyte(int'(bus.mem_addr)*4 + 3), rbyte(int'(bus.mem_addr)*4 + 2),
                          rbyte(int'(bus.mem_addr)*4 + 1), rbyte(int'(bus.mem_addr)*4)};
      end
    end
  end

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } acc_t;
  acc_t log_q[$];

  always @(negedge clk) begin
    if (bus.mem_en) begin
      log_q.push_back('{we: bus.mem_we, be: bus.mem_be, addr: bus.mem_addr, wdata: bus.mem_wdata});
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_acc(input string tag, input int idx, input logic we,
                         input logic [3:0] be, input logic [4:0] addr, input logic [31:0] wdata);
    if (idx >= log_q.size()) begin
      chk({tag, "_present"}, 32'(log_q.size()), 32'(idx + 1));
    end else begin
      chk({tag, "_we"},    {31'd0, log_q[idx].we}, {31'd0, we});
      chk({tag, "_be"},    {28'd0, log_q[idx].be}, {28'd0, be});
      chk({tag, "_addr"},  {27'd0, log_q[idx].addr}, {27'd0, addr});
      chk({tag, "_wdata"}, log_q[idx].wdata, wdata);
    end
  endtask

  // One full request/response; hold = cycles rsp_ready stays low once rsp_valid rises
  task automatic run_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input int hold,
                         output logic [31:0] rd, output logic er, output int lat, output int nacc);
    log_q.delete();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = st;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    chk("req_ready_idle", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("rsp_valid_seen", {31'd0, bus.rsp_valid}, 32'd1);
    chk("req_ready_busy", {31'd0, bus.req_ready}, 32'd0);
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      chk("hold_valid", {31'd0, bus.rsp_valid}, 32'd1);
      chk("hold_rdata", bus.rsp_rdata, rd);
      chk("hold_ready", {31'd0, bus.req_ready}, 32'd0);
    end
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", {31'd0, bus.rsp_valid}, 32'd0);
    chk("req_ready_back", {31'd0, bus.req_ready}, 32'd1);
    nacc = log_q.size();
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat;
  int          nacc;
  int          n;

  initial begin
    rst_n          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.rsp_ready  = 1'b0;
    #1;
    chk("rst_req_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
    chk("rst_mem_en",    {31'd0, bus.mem_en},    32'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_req_ready", {31'd0, bus.req_ready}, 32'd1);

    // Plain loads
    run_req(1'b0, 3'b000, 32'h05, 32'd0, 0, rd, er, lat, nacc);
    chk("lb05_rdata", rd, 32'hFFFFFF85);
    chk("lb05_err", {31'd0, er}, 32'd0);
    chk("lb05_lat", 32'(lat), 32'd3);
    chk("lb05_nacc", 32'(nacc), 32'd1);
    chk_acc("lb05_acc", 0, 1'b0, 4'b0010, 5'd1, 32'd0);
    run_req(1'b0, 3'b100, 32'h05, 32'd0, 0, rd, er, lat, nacc);
    chk("lbu05_rdata", rd, 32'h00000085);
    run_req(1'b0, 3'b001, 32'h06, 32'd0, 0, rd, er, lat, nacc);
    chk("lh06_rdata", rd, 32'hFFFF8786);

    // Word-crossing load
    run_req(1'b0, 3'b010, 32'h0E, 32'd0, 0, rd, er, lat, nacc);
`ifdef MISALIGN_TRAP_EN
    chk("lw0e_err", {31'd0, er}, 32'd1);
    chk("lw0e_rdata", rd, 32'd0);
    chk("lw0e_nacc", 32'(nacc), 32'd0);
    chk("lw0e_lat", 32'(lat), 32'd1);
`else
    chk("lw0e_rdata", rd, 32'h91908F8E);
    chk("lw0e_err", {31'd0, er}, 32'd0);
    chk("lw0e_lat", 32'(lat), 32'd5);
    chk("lw0e_nacc", 32'(nacc), 32'd2);
    chk_acc("lw0e_acc0", 0, 1'b0, 4'b1100, 5'd3, 32'd0);
    chk_acc("lw0e_acc1", 1, 1'b0, 4'b0011, 5'd4, 32'd0);
`endif

    // Single-word store then read-back
    run_req(1'b1, 3'b000, 32'h41, 32'h0000005A, 0, rd, er, lat, nacc);
    chk("sb41_lat", 32'(lat), 32'd2);
    chk("sb41_rdata", rd, 32'd0);
    chk_acc("sb41_acc", 0, 1'b1, 4'b0010, 5'd16, 32'h00005A00);
    run_req(1'b0, 3'b100, 32'h41, 32'd0, 0, rd, er, lat, nacc);
    chk("lbu41_rdata", rd, 32'h0000005A);

    // Error paths
    run_req(1'b1, 3'b010, 32'h7E, 32'h12345678, 0, rd, er, lat, nacc);
    chk("sw7e_err", {31'd0, er}, 32'd1);
    chk("sw7e_rdata", rd, 32'd0);
    chk("sw7e_nacc", 32'(nacc), 32'd0);
    chk("sw7e_lat", 32'(lat), 32'd1);
    run_req(1'b0, 3'b011, 32'h05, 32'd0, 0, rd, er, lat, nacc);
    chk("f3_011_err", {31'd0, er}, 32'd1);
    chk("f3_011_nacc", 32'(nacc), 32'd0);
    run_req(1'b0, 3'b010, 32'hFFFFFFFF, 32'd0, 0, rd, er, lat, nacc);
    chk("lwffff_err", {31'd0, er}, 32'd1);
    chk("lwffff_nacc", 32'(nacc), 32'd0);
    run_req(1'b0, 3'b000, 32'h7F, 32'd0, 0, rd, er, lat, nacc);
    chk("lb7f_err", {31'd0, er}, 32'd0);
    chk("lb7f_rdata", rd, 32'hFFFFFFFF);

    // Response held off for four cycles
    run_req(1'b0, 3'b001, 32'h06, 32'd0, 4, rd, er, lat, nacc);
    chk("hold_lh06_rdata", rd, 32'hFFFF8786);

    // A request presented during the consuming cycle is taken one cycle later
    run_req(1'b0, 3'b100, 32'h05, 32'd0, 0, rd, er, lat, nacc);
    log_q.delete();
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b0;
    bus.req_funct3 = 3'b100;
    bus.req_addr   = 32'h09;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    chk("b2b_not_taken", {31'd0, bus.mem_en}, 32'd0);
    chk("b2b_idle_ready", {31'd0, bus.req_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("b2b_taken", {31'd0, bus.mem_en}, 32'd1);
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("b2b2_rdata", bus.rsp_rdata, 32'h00000089);
    @(negedge clk);
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;

    // Reset while a store is in flight
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_store  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_wdata  = 32'h11223344;
`ifdef MISALIGN_TRAP_EN
    bus.req_addr   = 32'h20;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("rst_issue0_en", {31'd0, bus.mem_en}, 32'd1);
`else
    bus.req_addr   = 32'h21;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    chk("sw21_issue0_be", {28'd0, bus.mem_be}, 32'h0000000E);
    @(posedge clk);
    #1;
    chk("sw21_issue1_en", {31'd0, bus.mem_en}, 32'd1);
    chk("sw21_issue1_be", {28'd0, bus.mem_be}, 32'h00000001);
    chk("sw21_issue1_addr", {27'd0, bus.mem_addr}, 32'd9);
    chk("sw21_issue1_wdata", bus.mem_wdata, 32'h00000011);
`endif
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_en", {31'd0, bus.mem_en}, 32'd0);
    chk("mid_rst_be", {28'd0, bus.mem_be}, 32'd0);
    chk("mid_rst_ready", {31'd0, bus.req_ready}, 32'd0);
    chk("mid_rst_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
      chk("post_rst_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
    end
    run_req(1'b0, 3'b010, 32'h00, 32'd0, 0, rd, er, lat, nacc);
    chk("lw00_rdata", rd, 32'h83828180);
    chk("lw00_lat", 32'(lat), 32'd3);

    // Word-crossing halfword store and read-back
    run_req(1'b1, 3'b001, 32'h03, 32'h0000BEEF, 0, rd, er, lat, nacc);
`ifdef MISALIGN_TRAP_EN
    chk("sh03_err", {31'd0, er}, 32'd1);
    chk("sh03_nacc", 32'(nacc), 32'd0);
    run_req(1'b0, 3'b101, 32'h03, 32'd0, 0, rd, er, lat, nacc);
    chk("lhu03_err", {31'd0, er}, 32'd1);
`else
    chk("sh03_lat", 32'(lat), 32'd3);
    chk("sh03_nacc", 32'(nacc), 32'd2);
    chk_acc("sh03_acc0", 0, 1'b1, 4'b1000, 5'd0, 32'hEF000000);
    chk_acc("sh03_acc1", 1, 1'b1, 4'b0001, 5'd1, 32'h000000BE);
    run_req(1'b0, 3'b101, 32'h03, 32'd0, 0, rd, er, lat, nacc);
    chk("lhu03_rdata", rd, 32'h0000BEEF);
    chk("lhu03_lat", 32'(lat), 32'd5);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
